// File: rtl/conv_config_loader.sv
// Config front-end: assembles a 34-byte little-endian layer descriptor from {addr,byte} writes
// and holds it stable for the conv controller until layer_done re-opens loading.
module conv_config_loader #(
  parameter int unsigned CONFIG_ADDR_WIDTH      = 8,
  parameter int unsigned CONFIG_DATA_WIDTH      = 8,
  parameter int unsigned WEIGHT_BANK_ADDR_WIDTH = 13,
  parameter int unsigned IFMAP_BANK_ADDR_WIDTH  = 13,
  parameter int unsigned OFMAP_BANK_ADDR_WIDTH  = 8,
  parameter int unsigned COUNTER_WIDTH          = 32
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1:0] config_data_i,
  input  logic                                         config_vld_i,
  output logic                                         config_rdy_o,
  input  logic                                         layer_done_i,
  output logic                                         cfg_vld_o,
  output logic                                         cfg_err_o,
  output logic [WEIGHT_BANK_ADDR_WIDTH-1:0]            cfg_weight_max_adr_o,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_ifmap_max_wadr_o,
  output logic [OFMAP_BANK_ADDR_WIDTH-1:0]             cfg_ofmap_max_adr_o,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_ox0_o,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_oy0_o,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_fx_o,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_fy_o,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_stride_o,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_ix0_o,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_iy0_o,
  output logic [IFMAP_BANK_ADDR_WIDTH-1:0]             cfg_ic1_o,
  output logic [COUNTER_WIDTH-1:0]                     cfg_oc1_o,
  output logic [COUNTER_WIDTH-1:0]                     cfg_ic1_fy_fx_oy0_ox0_o,
  output logic [COUNTER_WIDTH-1:0]                     cfg_oy0_ox0_o
);

  localparam int unsigned NumBytes = 34;

  typedef enum logic {StLoad, StArmed} state_e;

  // Replace byte lane `sel` of a zero-extended field image.
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] sel,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{sel, 3'b000} +: 8] = b;
    return w;
  endfunction

  state_e                            state_q, state_d;
  logic [NumBytes-1:0]               mask_q, mask_d;
  logic                              err_q, err_d;
  logic                              live_q;
  logic [WEIGHT_BANK_ADDR_WIDTH-1:0] weight_q, weight_d;
  logic [IFMAP_BANK_ADDR_WIDTH-1:0]  ifmax_q, ifmax_d;
  logic [OFMAP_BANK_ADDR_WIDTH-1:0]  ofmax_q, ofmax_d;
  // geo: ox0, oy0, fx, fy, stride, ix0, iy0, ic1 (bytes 6..21)
  logic [IFMAP_BANK_ADDR_WIDTH-1:0]  geo_q [8];
  logic [IFMAP_BANK_ADDR_WIDTH-1:0]  geo_d [8];
  // cnt: oc1, ic1_fy_fx_oy0_ox0, oy0_ox0 (bytes 22..33)
  logic [COUNTER_WIDTH-1:0]          cnt_q [3];
  logic [COUNTER_WIDTH-1:0]          cnt_d [3];

  logic [31:0] waddr;
  logic [31:0] coff;
  logic [7:0]  wbyte;
  logic        accept;

  assign waddr  = 32'(config_data_i[CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1:CONFIG_DATA_WIDTH]);
  assign coff   = waddr - 32'd22;
  assign wbyte  = config_data_i[7:0];
  assign accept = config_vld_i & config_rdy_o;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    err_d    = err_q;
    weight_d = weight_q;
    ifmax_d  = ifmax_q;
    ofmax_d  = ofmax_q;
    geo_d    = geo_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StLoad: begin
        if (accept && waddr < NumBytes) begin
          if (waddr[31:1] == 31'd0) begin
            weight_d = WEIGHT_BANK_ADDR_WIDTH'(put_byte(32'(weight_q), {1'b0, waddr[0]}, wbyte));
          end
          if (waddr[31:1] == 31'd1) begin
            ifmax_d = IFMAP_BANK_ADDR_WIDTH'(put_byte(32'(ifmax_q), {1'b0, waddr[0]}, wbyte));
          end
          if (waddr[31:1] == 31'd2) begin
            ofmax_d = OFMAP_BANK_ADDR_WIDTH'(put_byte(32'(ofmax_q), {1'b0, waddr[0]}, wbyte));
          end
          for (int i = 0; i < 8; i++) begin
            if (waddr[31:1] == 31'(3 + i)) begin
              geo_d[i] = IFMAP_BANK_ADDR_WIDTH'(put_byte(32'(geo_q[i]), {1'b0, waddr[0]}, wbyte));
            end
          end
          for (int i = 0; i < 3; i++) begin
            if (coff[31:2] == 30'(i)) begin
              cnt_d[i] = COUNTER_WIDTH'(put_byte(32'(cnt_q[i]), coff[1:0], wbyte));
            end
          end
          mask_d[waddr[5:0]] = 1'b1;
          // Mandatory-field check uses the values as they will be once this byte lands.
          if (&mask_d) begin
            state_d = StArmed;
            err_d   = (geo_d[0] == '0) || (geo_d[1] == '0) || (geo_d[2] == '0) ||
                      (geo_d[3] == '0) || (geo_d[4] == '0) || (geo_d[7] == '0) ||
                      (cnt_d[0] == '0);
          end
        end
      end
      StArmed: begin
        if (layer_done_i) begin
          state_d = StLoad;
          mask_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StLoad;
      mask_q   <= '0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
      weight_q <= '0;
      ifmax_q  <= '0;
      ofmax_q  <= '0;
      geo_q    <= '{default: '0};
      cnt_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
      weight_q <= weight_d;
      ifmax_q  <= ifmax_d;
      ofmax_q  <= ofmax_d;
      geo_q    <= geo_d;
      cnt_q    <= cnt_d;
    end
  end

  // live_q keeps rdy low until the first edge after reset release.
  assign config_rdy_o = (state_q == StLoad) & live_q;
  assign cfg_vld_o    = (state_q == StArmed);
  assign cfg_err_o    = err_q;

  assign cfg_weight_max_adr_o    = weight_q;
  assign cfg_ifmap_max_wadr_o    = ifmax_q;
  assign cfg_ofmap_max_adr_o     = ofmax_q;
  assign cfg_ox0_o               = geo_q[0];
  assign cfg_oy0_o               = geo_q[1];
  assign cfg_fx_o                = geo_q[2];
  assign cfg_fy_o                = geo_q[3];
  assign cfg_stride_o            = geo_q[4];
  assign cfg_ix0_o               = geo_q[5];
  assign cfg_iy0_o               = geo_q[6];
  assign cfg_ic1_o               = geo_q[7];
  assign cfg_oc1_o               = cnt_q[0];
  assign cfg_ic1_fy_fx_oy0_ox0_o = cnt_q[1];
  assign cfg_oy0_ox0_o           = cnt_q[2];

endmodule
